sysmul_digit_feeder: RTL and testbench



---
 rtl/sysmul_pkg.sv | 28 ++
 rtl/sysmul_opnd_shreg.sv | 35 +++
 rtl/sysmul_digit_feeder.sv | 165 ++++++++++++++++
 tb/tb_sysmul_digit_feeder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sysmul_pkg.sv
// Shared constants, types and FSM encoding for the GF(2^163) systolic multiplier digit feeder.
package sysmul_pkg;

  localparam int unsigned M         = 163;
  localparam int unsigned D         = 8;
  localparam int unsigned NDIG      = (M + D - 1) / D;
  localparam int unsigned FLUSH_CYC = 21;
  localparam int unsigned OPW       = NDIG * D;
  localparam int unsigned CNT_MAX   = (NDIG > FLUSH_CYC) ? NDIG : FLUSH_CYC;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX);

  typedef logic [D-1:0]     digit_t;
  typedef logic [OPW-1:0]   opnd_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Padding bits above M are forced to zero so they never reach the bus.
  function automatic opnd_t zext(input logic [M-1:0] v);
    return {{(OPW - M){1'b0}}, v};
  endfunction

endpackage

// File: rtl/sysmul_opnd_shreg.sv
// Parallel-load operand register that shifts left one digit per step and presents its top digit.
module sysmul_opnd_shreg
  import sysmul_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   shift_i,
  input  opnd_t  data_i,
  output digit_t dig_o
);

  opnd_t sr_q, sr_d;

  // Zeros shift in, so the register is empty once every digit has been sent.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[OPW-D-1:0], {D{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dig_o = sr_q[OPW-1 -: D];

endmodule

// File: rtl/sysmul_digit_feeder.sv
// Digit-serial transmit feeder for the GF(2^163) systolic multiplier: MSB-digit-first a/b/g plus ctr framing.
// Optional operand prefetch buffer enabled by defining SYSMUL_FEED_PREFETCH_EN.
module sysmul_digit_feeder
  import sysmul_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a_op,
  input  logic [M-1:0] b_op,
  input  logic [M-1:0] g_op,
  output logic [D-1:0] a_dig,
  output logic [D-1:0] b_dig,
  output logic [D-1:0] g_dig,
  output logic         ctr,
  output logic         dig_valid,
  output logic         busy,
  output logic         op_done
);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   accept;
  logic   load;
  logic   shift;
  opnd_t  a_src, b_src, g_src;

`ifdef SYSMUL_FEED_PREFETCH_EN
  opnd_t a_buf_q, b_buf_q, g_buf_q;
  logic  buf_full_q, buf_full_d;
  logic  buf_take;
  logic  direct;
  logic  buf_wr;

  // The buffer drains in DONE; an accept in that same cycle refills it.
  assign buf_take = (state_q == ST_DONE) && buf_full_q;
  assign in_ready = !rst && (!buf_full_q || buf_take);
  assign accept   = in_valid && in_ready;
  assign direct   = accept && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && !buf_full_q));
  assign buf_wr   = accept && !direct;
  assign load     = direct || buf_take;

  assign a_src = buf_take ? a_buf_q : zext(a_op);
  assign b_src = buf_take ? b_buf_q : zext(b_op);
  assign g_src = buf_take ? g_buf_q : zext(g_op);

  always_comb begin
    buf_full_d = buf_full_q;
    if (buf_wr) begin
      buf_full_d = 1'b1;
    end else if (buf_take) begin
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_q <= 1'b0;
      a_buf_q    <= '0;
      b_buf_q    <= '0;
      g_buf_q    <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      if (buf_wr) begin
        a_buf_q <= zext(a_op);
        b_buf_q <= zext(b_op);
        g_buf_q <= zext(g_op);
      end
    end
  end
`else
  assign in_ready = !rst && (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign load     = accept;
  assign a_src    = zext(a_op);
  assign b_src    = zext(b_op);
  assign g_src    = zext(g_op);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_SEND;
          cnt_d   = cnt_t'(NDIG - 1);
        end
      end
      ST_SEND: begin
        shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FLUSH;
          cnt_d   = cnt_t'(FLUSH_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (load) begin
          state_d = ST_SEND;
          cnt_d   = cnt_t'(NDIG - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  sysmul_opnd_shreg u_a_sr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (a_src),
    .dig_o   (a_dig)
  );

  sysmul_opnd_shreg u_b_sr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (b_src),
    .dig_o   (b_dig)
  );

  sysmul_opnd_shreg u_g_sr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (g_src),
    .dig_o   (g_dig)
  );

  // The first digit of a frame carries ctr=0 so the PE loads b and clears incoming t.
  assign dig_valid = (state_q == ST_SEND);
  assign ctr       = (state_q == ST_SEND) && (cnt_q != cnt_t'(NDIG - 1));
  assign busy      = (state_q == ST_SEND) || (state_q == ST_FLUSH);
  assign op_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_sysmul_digit_feeder.sv
// Self-checking bench for sysmul_digit_feeder (default build): timeline model plus literal spot checks.
module tb_sysmul_digit_feeder;
  import sysmul_pkg::*;

  localparam int unsigned MIN_GAP = NDIG + FLUSH_CYC + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a_op, b_op, g_op;
  logic [D-1:0] a_dig, b_dig, g_dig;
  logic         ctr, dig_valid, busy, op_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sysmul_digit_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_op      (a_op),
    .b_op      (b_op),
    .g_op      (g_op),
    .a_dig     (a_dig),
    .b_dig     (b_dig),
    .g_dig     (g_dig),
    .ctr       (ctr),
    .dig_valid (dig_valid),
    .busy      (busy),
    .op_done   (op_done)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation is just an acceptance cycle plus the three operands.
  int unsigned   cyc = 0;
  bit            checking = 1'b0;
  bit            active = 1'b0;
  int unsigned   t_acc = 0;
  logic [OPW-1:0] ma, mb, mg;

  function automatic bit m_ready();
    return !rst && (!active || (cyc - t_acc >= MIN_GAP));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      active   = 1'b0;
      checking = 1'b1;
    end else if (in_valid && m_ready()) begin
      active = 1'b1;
      t_acc  = cyc;
      ma = {{(OPW - M){1'b0}}, a_op};
      mb = {{(OPW - M){1'b0}}, b_op};
      mg = {{(OPW - M){1'b0}}, g_op};
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    int unsigned p;
    int unsigned k;
    logic [7:0] ea, eb, eg;
    logic ectr, edv, ebusy, edone;
    if (checking) begin
      ea = '0; eb = '0; eg = '0;
      ectr = 1'b0; edv = 1'b0; ebusy = 1'b0; edone = 1'b0;
      if (active) begin
        p = cyc - t_acc;
        if (p >= 1 && p <= NDIG) begin
          k    = NDIG - p;
          ea   = ma[8*k +: 8];
          eb   = mb[8*k +: 8];
          eg   = mg[8*k +: 8];
          edv  = 1'b1;
          ectr = (p >= 2);
        end
        ebusy = (p >= 1) && (p <= NDIG + FLUSH_CYC);
        edone = (p == NDIG + FLUSH_CYC + 1);
      end
      cmp("a_dig", a_dig, ea);
      cmp("b_dig", b_dig, eb);
      cmp("g_dig", g_dig, eg);
      cmp("ctr", ctr, ectr);
      cmp("dig_valid", dig_valid, edv);
      cmp("busy", busy, ebusy);
      cmp("op_done", op_done, edone);
      cmp("in_ready", in_ready, m_ready());
    end
  end

  function automatic logic [M-1:0] rnd();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[M-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    // Reset held with in_valid asserted: nothing may be latched.
    rst = 1'b1; in_valid = 1'b1;
    a_op = rnd(); b_op = rnd(); g_op = rnd();
    step();
    neg();
    cmp("rst_dig_valid", dig_valid, 0);
    cmp("rst_in_ready", in_ready, 0);
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    neg();
    cmp("ready_after_rst", in_ready, 1);
    cmp("no_latch_in_rst", busy, 0);

    // a=1, b=1, g=0xC9
    @(posedge clk); #1;
    a_op = '0; a_op[0] = 1'b1;
    b_op = '0; b_op[0] = 1'b1;
    g_op = '0; g_op[7:0] = 8'hC9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    neg();
    cmp("t1_a", a_dig, 8'h00);
    cmp("t1_g", g_dig, 8'h00);
    cmp("t1_ctr", ctr, 0);
    cmp("t1_dv", dig_valid, 1);
    neg();
    cmp("t2_ctr", ctr, 1);
    repeat (19) neg();
    cmp("t21_a", a_dig, 8'h01);
    cmp("t21_b", b_dig, 8'h01);
    cmp("t21_g", g_dig, 8'hC9);
    cmp("t21_ctr", ctr, 1);
    neg();
    cmp("t22_dv", dig_valid, 0);
    repeat (20) neg();
    cmp("t42_done", op_done, 0);
    cmp("t42_busy", busy, 1);
    neg();
    cmp("t43_done", op_done, 1);
    cmp("t43_busy", busy, 0);
    cmp("t43_ready", in_ready, 0);

    // a = 2^162, b = all ones
    @(posedge clk); #1;
    a_op = '0; a_op[M-1] = 1'b1;
    b_op = '1;
    g_op = rnd();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    neg();
    cmp("msb_a0", a_dig, 8'h04);
    cmp("msb_b0", b_dig, 8'h07);
    neg();
    cmp("msb_a1", a_dig, 8'h00);
    cmp("msb_b1", b_dig, 8'hFF);
    repeat (50) neg();

    // Reset during SEND aborts without op_done
    @(posedge clk); #1;
    a_op = rnd(); b_op = rnd(); g_op = rnd();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    neg();
    cmp("abort_dv", dig_valid, 0);
    cmp("abort_busy", busy, 0);
    cmp("abort_a", a_dig, 8'h00);
    repeat (50) neg();
    @(posedge clk); #1;
    a_op = rnd(); b_op = rnd(); g_op = rnd();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (50) neg();

    // in_valid held high with operands changing every cycle
    @(posedge clk); #1;
    in_valid = 1'b1;
    a_op = rnd(); b_op = rnd(); g_op = rnd();
    step();
    a_op = rnd(); b_op = rnd(); g_op = rnd();
    repeat (42) begin
      step();
      a_op = rnd(); b_op = rnd(); g_op = rnd();
    end
    neg();
    cmp("b2b_ready_t43", in_ready, 0);
    @(posedge clk); #1;
    a_op = rnd(); b_op = rnd(); g_op = rnd();
    neg();
    cmp("b2b_ready_t44", in_ready, 1);
    repeat (60) begin
      step();
      a_op = rnd(); b_op = rnd(); g_op = rnd();
    end
    in_valid = 1'b0;
    repeat (50) neg();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
